// File: rtl/exe_writeback_collector.sv
// Execute-stage return path: buffers per-unit results and retires
// the two oldest (by sid) into the two writeback ports each cycle.
module exe_writeback_collector #(
  parameter int FIFO_DEPTH = 2,
  parameter int SID_W      = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             alu0_res_valid_i,
  output logic             alu0_res_ready_o,
  input  logic             alu0_res_rd_valid_i,
  input  logic [4:0]       alu0_res_rd_i,
  input  logic [1:0]       alu0_res_rd_type_i,
  input  logic [63:0]      alu0_res_value_i,
  input  logic [SID_W-1:0] alu0_res_sid_i,
  input  logic             alu0_res_endsim_i,
  input  logic             alu1_res_valid_i,
  output logic             alu1_res_ready_o,
  input  logic             alu1_res_rd_valid_i,
  input  logic [4:0]       alu1_res_rd_i,
  input  logic [1:0]       alu1_res_rd_type_i,
  input  logic [63:0]      alu1_res_value_i,
  input  logic [SID_W-1:0] alu1_res_sid_i,
  input  logic             alu1_res_endsim_i,
  input  logic             beu_res_valid_i,
  output logic             beu_res_ready_o,
  input  logic             beu_res_rd_valid_i,
  input  logic [4:0]       beu_res_rd_i,
  input  logic [1:0]       beu_res_rd_type_i,
  input  logic [63:0]      beu_res_value_i,
  input  logic [SID_W-1:0] beu_res_sid_i,
  input  logic             beu_res_endsim_i,
  input  logic             lsu_res_valid_i,
  output logic             lsu_res_ready_o,
  input  logic             lsu_res_rd_valid_i,
  input  logic [4:0]       lsu_res_rd_i,
  input  logic [1:0]       lsu_res_rd_type_i,
  input  logic [63:0]      lsu_res_value_i,
  input  logic [SID_W-1:0] lsu_res_sid_i,
  input  logic             lsu_res_endsim_i,
  output logic             wb0_valid_o,
  output logic             wb0_rd_valid_o,
  output logic [4:0]       wb0_rd_o,
  output logic [1:0]       wb0_rd_type_o,
  output logic [63:0]      wb0_value_o,
  output logic [SID_W-1:0] wb0_sid_o,
  output logic             wb0_endsim_o,
  output logic             wb1_valid_o,
  output logic             wb1_rd_valid_o,
  output logic [4:0]       wb1_rd_o,
  output logic [1:0]       wb1_rd_type_o,
  output logic [63:0]      wb1_value_o,
  output logic [SID_W-1:0] wb1_sid_o,
  output logic             wb1_endsim_o
);

  localparam int NU = 4;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef struct packed {
    logic             rd_valid;
    logic [4:0]       rd;
    logic [1:0]       rd_type;
    logic [63:0]      value;
    logic [SID_W-1:0] sid;
    logic             endsim;
  } res_t;

  logic [NU-1:0] w_in_valid;
  logic [NU-1:0] w_ready;
  logic [NU-1:0] w_nempty;
  logic [NU-1:0] w_deq;
  res_t          w_in   [NU];
  res_t          w_head [NU];

  assign w_in_valid = {lsu_res_valid_i, beu_res_valid_i,
                       alu1_res_valid_i, alu0_res_valid_i};

  assign w_in[0] = '{rd_valid: alu0_res_rd_valid_i,
                     rd:       alu0_res_rd_i,
                     rd_type:  alu0_res_rd_type_i,
                     value:    alu0_res_value_i,
                     sid:      alu0_res_sid_i,
                     endsim:   alu0_res_endsim_i};
  assign w_in[1] = '{rd_valid: alu1_res_rd_valid_i,
                     rd:       alu1_res_rd_i,
                     rd_type:  alu1_res_rd_type_i,
                     value:    alu1_res_value_i,
                     sid:      alu1_res_sid_i,
                     endsim:   alu1_res_endsim_i};
  assign w_in[2] = '{rd_valid: beu_res_rd_valid_i,
                     rd:       beu_res_rd_i,
                     rd_type:  beu_res_rd_type_i,
                     value:    beu_res_value_i,
                     sid:      beu_res_sid_i,
                     endsim:   beu_res_endsim_i};
  assign w_in[3] = '{rd_valid: lsu_res_rd_valid_i,
                     rd:       lsu_res_rd_i,
                     rd_type:  lsu_res_rd_type_i,
                     value:    lsu_res_value_i,
                     sid:      lsu_res_sid_i,
                     endsim:   lsu_res_endsim_i};

  assign alu0_res_ready_o = w_ready[0];
  assign alu1_res_ready_o = w_ready[1];
  assign beu_res_ready_o  = w_ready[2];
  assign lsu_res_ready_o  = w_ready[3];

  for (genvar u = 0; u < NU; u++) begin : g_fifo
    res_t          r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wptr;
    logic [PW-1:0] r_rptr;
    logic [CW-1:0] r_cnt;
    logic          r_rdy;
    logic          w_push;
    logic          w_pop;
    logic [CW-1:0] w_cnt_nxt;

    // Pushes while not ready are dropped here, never corrupting state.
    assign w_push = w_in_valid[u] & r_rdy;
    assign w_pop  = w_deq[u];

    assign w_head[u]   = r_mem[r_rptr];
    assign w_nempty[u] = (r_cnt != '0);
    assign w_ready[u]  = r_rdy;

    always_comb begin
      w_cnt_nxt = r_cnt;
      case ({w_push, w_pop})
        2'b10:   w_cnt_nxt = r_cnt + 1'b1;
        2'b01:   w_cnt_nxt = r_cnt - 1'b1;
        default: w_cnt_nxt = r_cnt;
      endcase
    end

    always_ff @(posedge clk) begin
      if (w_push && !flush_i)
        r_mem[r_wptr] <= w_in[u];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_rdy  <= 1'b1;
      end else if (flush_i) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_cnt  <= '0;
        r_rdy  <= 1'b1;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + 1'b1;
        if (w_pop)
          r_rptr <= r_rptr + 1'b1;
        r_cnt <= w_cnt_nxt;
        r_rdy <= (w_cnt_nxt < DEPTH_C);
      end
    end
  end

  // MSB is the wrap bit; differing wrap bits invert the index order.
  function automatic logic older(input logic [SID_W-1:0] a,
                                 input logic [SID_W-1:0] b);
    if (a[SID_W-1] == b[SID_W-1])
      return a[SID_W-2:0] < b[SID_W-2:0];
    else
      return a[SID_W-2:0] > b[SID_W-2:0];
  endfunction

  logic [1:0] w_p0;
  logic [1:0] w_p1;
  logic       w_p0_v;
  logic       w_p1_v;

  // Strict compare keeps the lower unit index on equal sids.
  always_comb begin
    w_p0   = '0;
    w_p0_v = 1'b0;
    w_p1   = '0;
    w_p1_v = 1'b0;
    w_deq  = '0;
    for (int i = 0; i < NU; i++) begin
      if (w_nempty[i] &&
          (!w_p0_v || older(w_head[i].sid, w_head[w_p0].sid))) begin
        w_p0   = 2'(i);
        w_p0_v = 1'b1;
      end
    end
    for (int i = 0; i < NU; i++) begin
      if (w_nempty[i] && !(w_p0_v && (w_p0 == 2'(i))) &&
          (!w_p1_v || older(w_head[i].sid, w_head[w_p1].sid))) begin
        w_p1   = 2'(i);
        w_p1_v = 1'b1;
      end
    end
    if (w_p0_v)
      w_deq[w_p0] = 1'b1;
    if (w_p1_v)
      w_deq[w_p1] = 1'b1;
  end

  logic r_wb0_v;
  logic r_wb1_v;
  res_t r_wb0;
  res_t r_wb1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb0_v <= 1'b0;
      r_wb1_v <= 1'b0;
      r_wb0   <= '0;
      r_wb1   <= '0;
    end else if (flush_i) begin
      r_wb0_v <= 1'b0;
      r_wb1_v <= 1'b0;
    end else begin
      r_wb0_v <= w_p0_v;
      r_wb1_v <= w_p1_v;
      if (w_p0_v)
        r_wb0 <= w_head[w_p0];
      if (w_p1_v)
        r_wb1 <= w_head[w_p1];
    end
  end

  assign wb0_valid_o    = r_wb0_v;
  assign wb0_rd_valid_o = r_wb0.rd_valid;
  assign wb0_rd_o       = r_wb0.rd;
  assign wb0_rd_type_o  = r_wb0.rd_type;
  assign wb0_value_o    = r_wb0.value;
  assign wb0_sid_o      = r_wb0.sid;
  assign wb0_endsim_o   = r_wb0.endsim;

  assign wb1_valid_o    = r_wb1_v;
  assign wb1_rd_valid_o = r_wb1.rd_valid;
  assign wb1_rd_o       = r_wb1.rd;
  assign wb1_rd_type_o  = r_wb1.rd_type;
  assign wb1_value_o    = r_wb1.value;
  assign wb1_sid_o      = r_wb1.sid;
  assign wb1_endsim_o   = r_wb1.endsim;

endmodule
